// File: rtl/chan_demux_pkg.sv
// chan_demux_pkg: shared widths, destination codes and FIFO occupancy encodings
package chan_demux_pkg;
    localparam int PKT_W = 11;
    localparam logic DEST_OUT0 = 1'b0;
    localparam logic DEST_OUT1 = 1'b1;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_PART  = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;
    function automatic logic [1:0] occ_state(input int count, input int depth);
        return count == 0 ? OCC_EMPTY : (count == depth ? OCC_FULL : OCC_PART);
    endfunction
endpackage

// File: rtl/chan_fifo.sv
// chan_fifo: circular-buffer FIFO with registered EMPTY/PART/FULL occupancy state.
// Ports: clk, rst (sync, active-high); push/push_data write side (caller never
// pushes when full); pop_ready consumer ready; head_data/head_valid oldest entry;
// full derived only from registered state so it has no path from pop_ready.
module chan_fifo
    import chan_demux_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic             pop;
    // Valid is masked during reset so nothing is presented in the reset cycle.
    assign head_valid = ~rst & (state_q != OCC_EMPTY);
    assign full       = state_q == OCC_FULL;
    assign head_data  = mem_q[rd_ptr_q];
    always_comb begin
        pop      = head_valid & pop_ready;
        wr_ptr_d = push ? (wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        state_d  = occ_state(int'(count_d), DEPTH);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= OCC_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/chan_demux.sv
// chan_demux: joins a data and a select channel and steers each packet into one of two output FIFOs.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready payload channel;
// sel_data/sel_valid/sel_ready destination channel (0 -> out0, 1 -> out1), consumed jointly
// with the payload; out0_*/out1_* ready/valid FIFO heads; cnt0/cnt1 saturating per-output
// packet counters, present only when CHAN_DEMUX_STATS_EN is defined.
module chan_demux
    import chan_demux_pkg::*;
#(
    parameter int WIDTH = PKT_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sel_data,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef CHAN_DEMUX_STATS_EN
   ,output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);
    logic full0, full1, accept, push0, push1;
    // Only the selected FIFO's registered full flag gates acceptance, so a
    // blocked destination stalls the link even when the other side has room.
    always_comb begin
        accept = ~rst & in_valid & sel_valid & ~(sel_data == DEST_OUT1 ? full1 : full0);
        push0  = accept & (sel_data == DEST_OUT0);
        push1  = accept & (sel_data == DEST_OUT1);
    end
    assign in_ready  = accept;
    assign sel_ready = accept;
    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .push_data(in_data), .pop_ready(out0_ready),
        .head_data(out0_data), .head_valid(out0_valid), .full(full0)
    );
    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .push_data(in_data), .pop_ready(out1_ready),
        .head_data(out1_data), .head_valid(out1_valid), .full(full1)
    );
`ifdef CHAN_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    always_comb begin
        cnt0_d = push0 && cnt0_q != '1 ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d = push1 && cnt1_q != '1 ? cnt1_q + 1'b1 : cnt1_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_chan_demux.sv
// tb_chan_demux: self-checking bench for chan_demux (directed vector table,
// hand-written reset sequence, randomized traffic against a queue model).
// Counter checks are compiled in when CHAN_DEMUX_STATS_EN is defined.
module tb_chan_demux;
    localparam int W = 11;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [W-1:0] in_data;
    logic in_valid, in_ready, sel_data, sel_valid, sel_ready;
    logic [W-1:0] out0_data, out1_data;
    logic out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef CHAN_DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt0, cnt1;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q0[$], q1[$];
    int c0, c1;

    chan_demux #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel_data(sel_data), .sel_valid(sel_valid), .sel_ready(sel_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
`ifdef CHAN_DEMUX_STATS_EN
       ,.cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic iv, s, sv, r0, r1;
        logic e_rdy, e_v0;
        logic [W-1:0] e_d0;
        logic e_v1;
        logic [W-1:0] e_d1;
    } vec_t;
    vec_t vt[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic iv, input logic s, input logic sv,
                         input logic r0, input logic r1);
        in_data = d; in_valid = iv; sel_data = s; sel_valid = sv;
        out0_ready = r0; out1_ready = r1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model view: a FIFO holds an ordered list; full means the list already
    // holds DEPTH packets at the start of the cycle (pops free space next cycle).
    task automatic tick_model();
        bit acc, p0, p1, s;
        logic [W-1:0] d;
        #1;
        s = sel_data;
        d = in_data;
        acc = in_valid && sel_valid && ((s ? q1.size() : q0.size()) < DEPTH);
        chk("in_ready", in_ready, acc);
        chk("sel_ready", sel_ready, acc);
        chk("out0_valid", out0_valid, q0.size() > 0);
        if (q0.size() > 0) chk("out0_data", out0_data, q0[0]);
        chk("out1_valid", out1_valid, q1.size() > 0);
        if (q1.size() > 0) chk("out1_data", out1_data, q1[0]);
`ifdef CHAN_DEMUX_STATS_EN
        chk("cnt0", cnt0, c0);
        chk("cnt1", cnt1, c1);
`endif
        p0 = q0.size() > 0 && out0_ready;
        p1 = q1.size() > 0 && out1_ready;
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (s) begin q1.push_back(d); c1 = c1 < CMAX ? c1 + 1 : c1; end
            else   begin q0.push_back(d); c0 = c0 < CMAX ? c0 + 1 : c0; end
        end
        @(negedge clk);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        drive('0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b0;
        q0.delete(); q1.delete(); c0 = 0; c1 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //          d             iv s sv r0 r1 rdy v0 d0            v1 d1
        vt[0]  = '{11'b00111000001, 1, 0, 1, 1, 1, 1, 0, 11'h0, 0, 11'h0};
        vt[1]  = '{11'h000, 0, 0, 0, 1, 1, 0, 1, 11'b00111000001, 0, 11'h0};
        vt[2]  = '{11'h7FF, 1, 1, 1, 1, 1, 1, 0, 11'h0, 0, 11'h0};
        vt[3]  = '{11'h7C0, 1, 1, 1, 1, 1, 1, 0, 11'h0, 1, 11'h7FF};
        vt[4]  = '{11'h000, 0, 0, 0, 1, 1, 0, 0, 11'h0, 1, 11'h7C0};
        vt[5]  = '{11'h000, 0, 0, 0, 1, 1, 0, 0, 11'h0, 0, 11'h0};
        vt[6]  = '{11'h155, 1, 1, 1, 1, 0, 1, 0, 11'h0, 0, 11'h0};
        vt[7]  = '{11'h2AA, 1, 1, 1, 1, 0, 1, 0, 11'h0, 1, 11'h155};
        vt[8]  = '{11'h0F0, 1, 1, 1, 1, 0, 0, 0, 11'h0, 1, 11'h155};
        vt[9]  = '{11'h0F0, 1, 1, 1, 1, 1, 0, 0, 11'h0, 1, 11'h155};
        vt[10] = '{11'h0F0, 1, 1, 1, 1, 1, 1, 0, 11'h0, 1, 11'h2AA};
        vt[11] = '{11'h000, 0, 0, 0, 1, 1, 0, 0, 11'h0, 1, 11'h0F0};
        vt[12] = '{11'h000, 0, 0, 0, 1, 1, 0, 0, 11'h0, 0, 11'h0};
        for (int i = 13; i < 18; i++)
            vt[i] = '{11'h7DF, 1, 1, 0, 1, 1, 0, 0, 11'h0, 0, 11'h0};
        vt[18] = '{11'h7DF, 1, 0, 1, 1, 1, 1, 0, 11'h0, 0, 11'h0};
        vt[19] = '{11'h000, 0, 0, 0, 1, 1, 0, 1, 11'h7DF, 0, 11'h0};
        vt[20] = '{11'h000, 0, 0, 0, 1, 1, 0, 0, 11'h0, 0, 11'h0};

        // Reset with both channels offering: nothing may be accepted or shown.
        rst = 1'b1;
        drive(11'h3FF, 1, 0, 1, 1, 1);
        @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sel_ready", sel_ready, 0);
        chk("rst_out0_valid", out0_valid, 0);
        chk("rst_out1_valid", out1_valid, 0);
        step();
        rst = 1'b0;
        drive('0, 0, 0, 0, 1, 1);
        #1;
        chk("post_rst_out0_valid", out0_valid, 0);
        chk("post_rst_out1_valid", out1_valid, 0);
        chk("post_rst_in_ready", in_ready, 0);
`ifdef CHAN_DEMUX_STATS_EN
        chk("post_rst_cnt0", cnt0, 0);
        chk("post_rst_cnt1", cnt1, 0);
`endif
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            drive(vt[i].d, vt[i].iv, vt[i].s, vt[i].sv, vt[i].r0, vt[i].r1);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_sel_ready", i), sel_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_out0_valid", i), out0_valid, vt[i].e_v0);
            if (vt[i].e_v0) chk($sformatf("vec%0d_out0_data", i), out0_data, vt[i].e_d0);
            chk($sformatf("vec%0d_out1_valid", i), out1_valid, vt[i].e_v1);
            if (vt[i].e_v1) chk($sformatf("vec%0d_out1_data", i), out1_data, vt[i].e_d1);
            step();
        end
`ifdef CHAN_DEMUX_STATS_EN
        chk("table_cnt0", cnt0, 2);
        chk("table_cnt1", cnt1, 5);
`endif

        // Mid-operation reset with two packets parked in out0.
        drive(11'h111, 1, 0, 1, 0, 0); step();
        drive(11'h222, 1, 0, 1, 0, 0); step();
        drive('0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_out0_valid", out0_valid, 1);
        chk("mid_out0_data", out0_data, 11'h111);
        rst = 1'b1;
        drive(11'h333, 1, 0, 1, 1, 1);
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out0_valid", out0_valid, 0);
        step();
        rst = 1'b0;
        drive('0, 0, 0, 0, 1, 1);
        #1;
        chk("mid_after_out0_valid", out0_valid, 0);
        chk("mid_after_out1_valid", out1_valid, 0);
`ifdef CHAN_DEMUX_STATS_EN
        chk("mid_after_cnt0", cnt0, 0);
        chk("mid_after_cnt1", cnt1, 0);
`endif
        step();
        #1;
        chk("mid_after2_out0_valid", out0_valid, 0);
        drive(11'b00000100000, 1, 1, 1, 1, 1);
        #1;
        chk("mid_send_in_ready", in_ready, 1);
        step();
        drive('0, 0, 0, 0, 1, 1);
        #1;
        chk("mid_out1_valid", out1_valid, 1);
        chk("mid_out1_data", out1_data, 11'b00000100000);
        chk("mid_out0_idle", out0_valid, 0);
        step();

        // Random traffic against the queue model.
        reset_all();
        for (int i = 0; i < 600; i++) begin
            drive(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            tick_model();
        end
        drive('0, 0, 0, 0, 1, 1);
        repeat (4) tick_model();

`ifdef CHAN_DEMUX_STATS_EN
        // Counter saturation: 20 packets into a CNT_W=4 counter.
        reset_all();
        for (int i = 0; i < 20; i++) begin
            drive(W'($urandom), 1, 0, 1, 1, 0);
            tick_model();
        end
        #1;
        chk("sat_cnt0", cnt0, 15);
        chk("sat_cnt1", cnt1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
